fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Instruction-fetch front end for the Lab4 CPU: owns the program counter and issues
//  single-outstanding read requests to instruction memory. Presents each fetched word,
//  tagged with its PC, to the decode stage over a valid/ready handshake.
//  Next-PC selection (sequential vs. redirect) goes through the 32-bit 2:1 mux.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk              in   1   system clock, all state on rising edge
//  reset            in   1   synchronous, active-high
//  stall            in   1   hazard unit: do not start a new fetch
//  redirect         in   1   branch/jump taken; 1-cycle pulse
//  redirect_target  in   32  new PC; bits [1:0] ignored (treated as 00)
//  imem_req         out  1   read request, held until imem_ack
//  imem_addr        out  32  word address of request, stable while imem_req=1
//  imem_ack         in   1   memory accepts request; imem_rdata valid same cycle
//  imem_rdata       in   32  instruction word
//  instr_valid      out  1   instr/instr_pc hold a fetched instruction
//  instr            out  32  fetched instruction
//  instr_pc         out  32  PC of instr
//  instr_ready      in   1   decode consumes instr this cycle
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC,
//   instr_valid=0, instr=0, instr_pc=0. All outputs registered.
//  States: IDLE, WAIT, SQUASH, HOLD.
//  IDLE: req=0. If !stall && !redirect -> WAIT, req<=1, imem_addr<=pc.
//  WAIT: req/addr held. On ack && !redirect: instr<=rdata, instr_pc<=pc, instr_valid<=1,
//   pc<=pc+4, -> HOLD. On ack && redirect: data dropped, pc<=target, -> IDLE.
//   redirect without ack: pc<=target, -> SQUASH. stall ignored in WAIT.
//  SQUASH: req/addr still held (old addr); on ack: data dropped, req<=0, -> IDLE.
//   Further redirects in SQUASH overwrite pc.
//  HOLD: instr_valid=1, instr/instr_pc stable until instr_ready.
//   instr_ready && !stall: instr_valid<=0, req<=1, imem_addr<=pc, -> WAIT (back-to-back).
//   instr_ready && stall: instr_valid<=0, -> IDLE.
//  redirect in IDLE/HOLD: instr_valid<=0 (instr discarded even if ready same cycle),
//   pc<=target, -> IDLE. redirect has priority over stall and ready; reset over all.
//  Next PC = mux(redirect ? target&~3 : pc+4); pc+4 wraps 32'hFFFF_FFFC -> 32'h0.
//  Latency: reset low at cycle 0 -> req=1 at cycle 1; ack at cycle N -> instr_valid
//   at N+1; ready at M (no stall) -> next req at M+1.
//  Reset mid-request abandons it; req drops next edge; imem tolerates abandonment.
//  Invariant: at most one request outstanding; never instr_valid=1 in WAIT/SQUASH.
// STRUCTURE
//  Shared package: state encoding (2-bit IDLE/WAIT/SQUASH/HOLD), PC_STEP=32'd4,
//   WORD_MASK=32'hFFFF_FFFC.
//  Sub-module: one mux2to1by32 instance for next-PC (address=redirect,
//   input0=pc+4, input1=target&WORD_MASK). FSM, PC and output regs live in this module.
// TESTING
//  1 Reset, ack=1 every cycle, ready=1 -> addr 0,4,8 issued; instr_pc 0,4,8 with rdata.
//  2 ack delayed 3 cycles at addr 0x10 -> req/addr stable 3 cycles; valid next cycle.
//  3 redirect to 0x200 while in WAIT at 0x40, ack 2 cycles later -> 0x40 data never
//    valid; next req addr 0x200.
//  4 redirect to 0x103 (misaligned) simultaneously with ack -> data dropped; next addr 0x100.
//  5 HOLD with ready=0 for 4 cycles -> instr/instr_pc unchanged; ready+stall -> IDLE,
//    no req until stall drops.
//  6 pc=0xFFFF_FFFC fetch -> next addr 0x0; reset asserted in WAIT -> req=0,
//    valid=0, addr=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding and PC constants.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2,
    HOLD   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_pc_unit_mux2to1by32.sv
// 32-bit 2:1 multiplexer used for next-PC selection.
module mux2to1by32 (
  input  logic        address,
  input  logic [31:0] input0,
  input  logic [31:0] input1,
  output logic [31:0] out
);

  assign out = address ? input1 : input0;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem read at a time,
// and hands fetched words (tagged with their PC) to decode over valid/ready.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         req_reg, req_next;
  logic [31:0]  addr_reg, addr_next;
  logic         valid_reg, valid_next;
  logic [31:0]  instr_reg, instr_next;
  logic [31:0]  ipc_reg, ipc_next;
  logic [31:0]  mux_out;
  logic         pc_load;

  mux2to1by32 u_next_pc_mux (
    .address (redirect),
    .input0  (pc_reg + PC_STEP),
    .input1  (redirect_target & WORD_MASK),
    .out     (mux_out)
  );

  // PC only moves on a redirect (any state) or when a fetch completes in WAIT.
  assign pc_load = redirect || (state_reg == WAIT && imem_ack);
  assign pc_next = pc_load ? mux_out : pc_reg;

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    valid_next = valid_reg;
    instr_next = instr_reg;
    ipc_next   = ipc_reg;
    unique case (state_reg)
      IDLE: begin
        if (!redirect && !stall) begin
          state_next = WAIT;
          req_next   = 1'b1;
          addr_next  = pc_reg;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          req_next = 1'b0;
          if (redirect) begin
            state_next = IDLE;
          end else begin
            state_next = HOLD;
            instr_next = imem_rdata;
            ipc_next   = pc_reg;
            valid_next = 1'b1;
          end
        end else if (redirect) begin
          state_next = SQUASH;
        end
      end
      SQUASH: begin
        // Request is still outstanding at the old address; drain it and drop the data.
        if (imem_ack) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (redirect) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end else if (instr_ready) begin
          valid_next = 1'b0;
          if (!stall) begin
            state_next = WAIT;
            req_next   = 1'b1;
            addr_next  = pc_reg;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      req_reg   <= 1'b0;
      addr_reg  <= RESET_PC;
      valid_reg <= 1'b0;
      instr_reg <= 32'd0;
      ipc_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
      instr_reg <= instr_next;
      ipc_reg   <= ipc_next;
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = addr_reg;
  assign instr_valid = valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = ipc_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; imem returns addr ^ 0xA5A5_0000 so each word identifies its address.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_checks = 0;
  int n_errors = 0;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] a);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, a);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    $display("txn %s: req addr=%h", tag, imem_addr);
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] a);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_pc"}, instr_pc, a);
    check({tag, "_instr"}, instr, mem_word(a));
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    $display("txn %s: instr_pc=%h instr=%h", tag, instr_pc, instr);
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    $display("txn %s: idle", tag);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
    imem_ack = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    // Reset state
    expect_quiet("rst");
    check("rst_addr", imem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_ipc", instr_pc, 32'd0);

    // 1: ack every cycle, ready every cycle -> 0,4,8,C
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); expect_req($sformatf("seq%0d", k), 32'(4 * k));
      tick(); expect_instr($sformatf("seq%0d", k), 32'(4 * k));
      if (k == 3) imem_ack = 1'b0;
    end

    // 2: ack held off 3 cycles at 0x10
    for (int k = 0; k < 3; k++) begin
      tick(); expect_req($sformatf("dly%0d", k), 32'h10);
    end
    imem_ack = 1'b1;
    instr_ready = 1'b0;
    tick(); expect_instr("dly_done", 32'h10);
    imem_ack = 1'b0;

    // 5: HOLD with ready low, then ready+stall -> IDLE with no request
    for (int k = 0; k < 4; k++) begin
      tick(); expect_instr($sformatf("hold%0d", k), 32'h10);
    end
    instr_ready = 1'b1; stall = 1'b1;
    tick(); expect_quiet("stall0");
    tick(); expect_quiet("stall1");
    redirect = 1'b1; redirect_target = 32'h40;
    tick(); expect_quiet("redir_idle");
    redirect = 1'b0; stall = 1'b0;

    // 3: redirect to 0x200 while waiting at 0x40, ack two cycles later
    tick(); expect_req("w40_a", 32'h40);
    tick(); expect_req("w40_b", 32'h40);
    redirect = 1'b1; redirect_target = 32'h200;
    tick(); expect_req("sq0", 32'h40);
    redirect = 1'b0;
    tick(); expect_req("sq1", 32'h40);
    imem_ack = 1'b1;
    tick(); expect_quiet("sq_drain");
    tick(); expect_req("r200", 32'h200);
    tick(); expect_instr("r200", 32'h200);
    tick(); expect_req("r204", 32'h204);

    // 4: misaligned redirect coincident with ack
    redirect = 1'b1; redirect_target = 32'h103;
    tick(); expect_quiet("ack_redir");
    redirect = 1'b0;
    tick(); expect_req("r100", 32'h100);
    tick(); expect_instr("r100", 32'h100);

    // Redirect in HOLD discards the held instruction; then wrap at top of memory
    instr_ready = 1'b0; redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick(); expect_quiet("hold_redir");
    redirect = 1'b0; instr_ready = 1'b1;
    tick(); expect_req("top", 32'hFFFF_FFFC);
    tick(); expect_instr("top", 32'hFFFF_FFFC);
    tick(); expect_req("wrap", 32'h0);
    tick(); expect_instr("wrap", 32'h0);
    tick(); expect_req("w4", 32'h4);
    imem_ack = 1'b0;
    tick(); expect_req("w4_wait", 32'h4);

    // 6: reset while a request is outstanding
    reset = 1'b1;
    tick();
    expect_quiet("rst_wait");
    check("rst_wait_addr", imem_addr, 32'd0);
    check("rst_wait_ipc", instr_pc, 32'd0);
    reset = 1'b0;
    tick(); expect_req("post_rst", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
